// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Sends a 32-bit word on a UART TX line as four back-to-back 8N1 frames.
//   Byte 0 (bits 7:0) goes first, and each byte is sent LSB first.
//   Optional macro UART_TX_PARITY_EN adds an even-parity bit after bit 7 of
//   every byte.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   TX_start     start strobe, sampled only while idle
//   UART_data    word to send, captured on the accepting edge
//   TX           serial line, idle high, registered
//   tx_dataready one-cycle pulse in the DONE cycle (whole word sent)
//   busy         high from acceptance through the DONE cycle
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TX_start,
  input  logic [31:0] UART_data,
  output logic        TX,
  output logic        tx_dataready,
  output logic        busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP, DONE
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic [31:0]   word, word_n;
  logic          tx_d;
  logic [7:0]    cur_byte_n;
  logic          last;

  // State register. TX is registered from the value the line must carry in
  // the next state, so the start bit appears at the accepting edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
      TX       <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      word     <= word_n;
      TX       <= tx_d;
    end
  end

  assign last = (baud == BAUD_MAX);

  // Next-state logic. The baud counter wraps at every bit boundary.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    word_n  = word;
    case (state)
      IDLE: if (TX_start) begin
        word_n  = UART_data;
        byte_n  = '0;
        bit_n   = '0;
        baud_n  = '0;
        state_n = START;
      end
      START: begin
        baud_n = last ? '0 : baud + BW'(1);
        if (last) state_n = DATA;
      end
      DATA: begin
        baud_n = last ? '0 : baud + BW'(1);
        if (last) begin
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_n = last ? '0 : baud + BW'(1);
        if (last) state_n = STOP;
      end
`endif
      STOP: begin
        baud_n = last ? '0 : baud + BW'(1);
        if (last) begin
          if (byte_idx == 2'd3) state_n = DONE;
          else begin
            byte_n  = byte_idx + 2'd1;
            state_n = START;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: line level for the upcoming state, plus status decodes of the
  // registered state.
  always_comb begin
    case (byte_n)
      2'd0:    cur_byte_n = word_n[7:0];
      2'd1:    cur_byte_n = word_n[15:8];
      2'd2:    cur_byte_n = word_n[23:16];
      default: cur_byte_n = word_n[31:24];
    endcase
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_n[bit_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^cur_byte_n;
`endif
      default: tx_d = 1'b1;
    endcase
    busy         = (state != IDLE);
    tx_dataready = (state == DONE);
  end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int N = 4 * FRAME * CPB;   // cycle index of the DONE cycle

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        TX_start = 1'b0;
  logic [31:0] UART_data = '0;
  logic        TX, tx_dataready, busy;

  int errors = 0;
  int checks = 0;

  uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .TX_start(TX_start), .UART_data(UART_data),
    .TX(TX), .tx_dataready(tx_dataready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  b0, b1, b2, b3;
    logic [3:0]  par;
    int          hold;
    bit          chg;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level k cycles after the acceptance edge, straight from the frame
  // layout: start 0, 8 data bits LSB first, optional even parity, stop 1.
  function automatic logic exp_tx(input logic [31:0] w, input int k);
    int f, b;
    logic [7:0] by;
    if (k >= N) return 1'b1;
    f  = k / (FRAME * CPB);
    b  = (k % (FRAME * CPB)) / CPB;
    by = w[8*f +: 8];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (PAR && b == 9) return ^by;
    return 1'b1;
  endfunction

  // Sends one word and checks every cycle through the idle cycle after DONE.
  // pre=1: strobe is already high from a previous word, acceptance is implicit.
  task automatic send(input logic [31:0] w, input int hold, input bit chg, input bit pre,
                      output logic [3:0][7:0] dec, output logic [3:0] par);
    int pulses, f, b;
    dec = '0;
    par = '0;
    pulses = 0;
    if (!pre) begin
      @(negedge clk);
      TX_start  = 1'b1;
      UART_data = w;
    end
    @(negedge clk);
    for (int k = 0; k <= N; k++) begin
      if (k == hold) TX_start = 1'b0;
      if (k == 0 && chg) UART_data = 32'h0;
      chk("tx_line", TX, exp_tx(w, k));
      chk("busy", busy, 1'b1);
      chk("dataready", tx_dataready, k == N);
      if (tx_dataready) pulses++;
      if (k < N && (k % CPB) == CPB / 2) begin
        f = k / (FRAME * CPB);
        b = (k % (FRAME * CPB)) / CPB;
        if (b >= 1 && b <= 8) dec[f][b-1] = TX;
        if (PAR && b == 9) par[f] = TX;
      end
      @(negedge clk);
    end
    chk("pulse_count", pulses, 1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_tx", TX, 1'b1);
    chk("idle_rdy", tx_dataready, 1'b0);
  endtask

  logic [3:0][7:0] dec;
  logic [3:0]      par;
  logic [31:0]     rw;

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000, 0,  1'b0};
    tbl[1] = '{32'hA5C3_0F81, 8'h81, 8'h0F, 8'hC3, 8'hA5, 4'b0000, 0,  1'b0};
    tbl[2] = '{32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12, 4'b0100, 50, 1'b0};
    tbl[3] = '{32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 4'b0101, 0,  1'b1};
    tbl[4] = '{32'h0000_0103, 8'h03, 8'h01, 8'h00, 8'h00, 4'b0010, 0,  1'b0};

    // Async reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", TX, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy", tx_dataready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset at cycle 70 of a word; line must go high without an edge.
    TX_start  = 1'b1;
    UART_data = 32'h0;
    @(negedge clk);
    TX_start = 1'b0;
    repeat (70) @(negedge clk);
    chk("pre_rst_tx", TX, exp_tx(32'h0, 70));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tx", TX, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdy", tx_dataready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_rdy", tx_dataready, 1'b0);
      chk("post_rst_tx", TX, 1'b1);
      @(negedge clk);
    end

    // Vector table.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].w, tbl[i].hold, tbl[i].chg, 1'b0, dec, par);
      chk("byte0", dec[0], tbl[i].b0);
      chk("byte1", dec[1], tbl[i].b1);
      chk("byte2", dec[2], tbl[i].b2);
      chk("byte3", dec[3], tbl[i].b3);
      if (PAR) chk("parity", par, tbl[i].par);
    end

    // Strobe held high across the whole word: re-accept only after DONE.
    send(32'hA5C3_0F81, N + 10, 1'b0, 1'b0, dec, par);
    send(32'hA5C3_0F81, 0, 1'b0, 1'b1, dec, par);
    chk("chain_byte0", dec[0], 8'h81);
    chk("chain_byte3", dec[3], 8'hA5);

    // Randomized words against the frame model.
    for (int i = 0; i < 8; i++) begin
      rw = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rw, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, dec, par);
      chk("rand_word", dec, rw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmitter for the debug link: accepts a 32-bit word with a start strobe and sends it on the TX line as four consecutive 8N1 UART frames, byte 0 (bits 7:0) first. Sits directly downstream of the debug unit's send state machine (which drives `TX_start`/`UART_data` and waits on `tx_dataready`) and drives the board TX pin. Contains its own baud-rate counter, bit shifter and byte sequencer.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `TX_start`  in  1  start strobe; sampled only in IDLE.
- `UART_data`  in  32  word to send; captured on the accepting edge.
- `TX`  out  1  serial line, idle high.
- `tx_dataready`  out  1  one-cycle pulse: whole word sent.
- `busy`  out  1  high from acceptance until the `tx_dataready` cycle inclusive.

## Operation
- Reset (async): state IDLE; `TX`=1, `tx_dataready`=0, `busy`=0; all counters and shift register cleared. Reset mid-frame aborts immediately, `TX` returns high in the same instant; no `tx_dataready`.
- States: IDLE, START, DATA, PARITY (only with macro), STOP, DONE.
- IDLE: `TX`=1. If `TX_start`=1 on a rising edge: latch `UART_data` into word register, byte index=0, bit index=0, baud count=0, go START, `busy`=1. `TX_start`=0: stay.
- START: `TX`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `TX`=current byte bit, LSB first; each bit `CLKS_PER_BIT` cycles; after bit 7 go PARITY (macro) or STOP.
- STOP: `TX`=1 for `CLKS_PER_BIT` cycles. At end: byte index 3 → DONE; else byte index+1, go START directly (no idle gap between bytes).
- DONE: one cycle; `tx_dataready`=1, `TX`=1, `busy`=1; next edge → IDLE.
- `TX_start` outside IDLE (including DONE) ignored; no queueing. `UART_data` changes after acceptance have no effect.
- `TX` is a registered output (no glitches).
- Baud counter: 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary; width $clog2(`CLKS_PER_BIT`).

## Timing
- Acceptance edge E0: `TX` falls at E0 (start bit begins the cycle after `TX_start` is sampled).
- Each bit exactly `CLKS_PER_BIT` cycles; frame 10 bits (11 with parity).
- Word duration: 40×`CLKS_PER_BIT` cycles without parity, 44× with.
- `tx_dataready` high in the cycle starting at E0 + 40×`CLKS_PER_BIT`; low otherwise.
- Earliest next acceptance: the edge after the DONE cycle; back-to-back word gap therefore ≥1 cycle idle high (debug unit's registered strobe gives 2).
- `busy` deasserts on the same edge that leaves DONE.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted after bit 7 of every byte, `TX`=even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles; word = 44×`CLKS_PER_BIT`.
- Undefined: no PARITY state; pure 8N1, 40×`CLKS_PER_BIT`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `TX`=1, `tx_dataready`=0, `busy`=0 without a clock edge.
- `CLKS_PER_BIT`=4, send 32'hA5C3_0F81 → line decodes bytes 81,0F,C3,A5 in order, each start=0/stop=1, every bit 4 cycles, `tx_dataready` single pulse at cycle 160 after acceptance.
- `TX_start` held high for 50 cycles during a transfer of 32'h1234_5678 → exactly one word sent, one `tx_dataready` pulse; second word starts only after DONE if strobe still high.
- Reset asserted at cycle 70 of a 160-cycle word → `TX` high immediately, no `tx_dataready`; following strobe with 32'hFFFF_FFFF sends cleanly.
- `UART_data` changed to 32'h0 the cycle after acceptance of 32'hDEAD_BEEF → line still carries EF,BE,AD,DE.
- With `UART_TX_PARITY_EN`, send 32'h0000_0103 → parity bits 0,1,0,0; `tx_dataready` at cycle 176 (`CLKS_PER_BIT`=4).
